caravel_mini: RTL and testbench

CARAVEL_MINI -- requirements
Module: caravel_mini

---
 rtl/caravel_mini_pkg.sv | 31 +++
 rtl/caravel_mini_uart_tx.sv | 54 +++++
 rtl/caravel_mini.sv | 177 +++++++++++++++++
 tb/tb_caravel_mini.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/caravel_mini_pkg.sv
// Shared constants for the caravel_mini boot controller: FSM encoding, SPI opcode,
// checkbit codes and the pad-enable pattern.
package caravel_mini_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_CMD  = 3'd0;
  localparam state_t ST_ADDR = 3'd1;
  localparam state_t ST_READ = 3'd2;
  localparam state_t ST_UART = 3'd3;
  localparam state_t ST_DONE = 3'd4;

  localparam logic [7:0]  SPI_READ_OP = 8'h03;
  localparam logic [23:0] SPI_BOOT_ADDR = 24'h000000;

  localparam logic [15:0] CHK_RESET = 16'h0000;
  localparam logic [15:0] CHK_BOOT  = 16'h0001;
  localparam logic [15:0] CHK_LATE  = 16'h0002;

  // Only the UART pin (bit 6) and the checkbits (31:16) are driven by the core.
  localparam logic [37:0] MPRJ_OEB = 38'h3F_0000_FFBF;

  localparam int UART_FRAME_BITS = 10;

  function automatic logic [15:0] checkbits_for(input state_t st, input logic run);
    if (!run) return CHK_RESET;
    if (st == ST_UART || st == ST_DONE) return CHK_LATE;
    return CHK_BOOT;
  endfunction

endpackage

// File: rtl/caravel_mini_uart_tx.sv
// Minimal 8N1 transmitter: one frame per start pulse, LSB first, idle high.
module uart_tx
  import caravel_mini_pkg::*;
#(
  parameter int UART_DIV = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy
);

  localparam int CW = (UART_DIV < 2) ? 1 : $clog2(UART_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(UART_DIV - 1);
  localparam logic [3:0] BIT_LAST = 4'(UART_FRAME_BITS - 1);

  logic                       busy_q;
  logic [UART_FRAME_BITS-1:0] frame_q;
  logic [CW-1:0]              cnt_q;
  logic [3:0]                 bit_q;

  // frame_q shifts right once per bit period; its LSB is always the bit on the wire.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q  <= 1'b0;
      frame_q <= '1;
      cnt_q   <= '0;
      bit_q   <= '0;
    end else if (!busy_q) begin
      if (start) begin
        busy_q  <= 1'b1;
        frame_q <= {1'b1, data, 1'b0};
        cnt_q   <= '0;
        bit_q   <= '0;
      end
    end else if (cnt_q == CNT_LAST) begin
      cnt_q   <= '0;
      frame_q <= {1'b1, frame_q[UART_FRAME_BITS-1:1]};
      if (bit_q == BIT_LAST) begin
        busy_q <= 1'b0;
      end else begin
        bit_q <= bit_q + 4'd1;
      end
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tx   = busy_q ? frame_q[0] : 1'b1;
  assign busy = busy_q;

endmodule

// File: rtl/caravel_mini.sv
// Boot controller: reads BOOT_WORDS words from SPI flash into a 512x32 SRAM,
// sends the low byte of word 0 on the UART pad, then flags completion on gpio.
module caravel_mini
  import caravel_mini_pkg::*;
#(
  parameter int BOOT_WORDS = 512,
  parameter int SPI_DIV    = 2,
  parameter int UART_DIV   = 434
) (
  input  logic        clock,
  input  logic        reset,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic        flash_io0,
  input  logic        flash_io1,
  input  logic [37:0] mprj_in,
  output logic [37:0] mprj_out,
  output logic [37:0] mprj_oeb,
  output logic        gpio,
  input  logic [8:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  if (BOOT_WORDS < 1 || BOOT_WORDS > 512) begin : g_bad_boot_words
    $error("caravel_mini: BOOT_WORDS must be within 1..512");
  end

  localparam int DIV_W = (SPI_DIV < 2) ? 1 : $clog2(SPI_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SPI_DIV - 1);
  localparam logic [8:0]       WORD_LAST = 9'(BOOT_WORDS - 1);

  state_t            state_q, state_d;
  logic              run_q, run_d;
  logic              sclk_q, sclk_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [4:0]        bit_q, bit_d;
  logic [31:0]       tx_sr_q, tx_sr_d;
  logic [7:0]        rx_byte_q, rx_byte_d;
  logic [23:0]       word_q, word_d;
  logic [8:0]        word_cnt_q, word_cnt_d;
  logic              last_q, last_d;
  logic              uart_sent_q, uart_sent_d;

  logic              spi_active;
  logic [7:0]        byte_now;
  logic              mem_we;
  logic [8:0]        mem_waddr;
  logic [31:0]       mem_wdata;
  logic              uart_start;
  logic              uart_busy;
  logic              uart_txd;
  logic [31:0]       mem_q [0:511];

  logic unused_mprj_in;
  assign unused_mprj_in = ^mprj_in;

  // run_q holds the flash deselected for the first cycle after reset release.
  assign spi_active = run_q && (state_q == ST_CMD || state_q == ST_ADDR || state_q == ST_READ);

  always_comb begin
    state_d     = state_q;
    run_d       = 1'b1;
    sclk_d      = sclk_q;
    div_d       = div_q;
    bit_d       = bit_q;
    tx_sr_d     = tx_sr_q;
    rx_byte_d   = rx_byte_q;
    word_d      = word_q;
    word_cnt_d  = word_cnt_q;
    last_d      = last_q;
    uart_sent_d = uart_sent_q;
    byte_now    = {rx_byte_q[6:0], flash_io1};
    mem_we      = 1'b0;
    mem_waddr   = word_cnt_q;
    mem_wdata   = {byte_now, word_q};
    uart_start  = 1'b0;

    if (spi_active) begin
      if (div_q == DIV_LAST) begin
        div_d  = '0;
        sclk_d = ~sclk_q;
        if (!sclk_q) begin
          // Rising edge: MISO is sampled here, MOSI only moves on the falling edge.
          if (state_q == ST_READ) begin
            rx_byte_d = byte_now;
            bit_d     = bit_q + 5'd1;
            if (bit_q == 5'd7) word_d[7:0] = byte_now;
            if (bit_q == 5'd15) word_d[15:8] = byte_now;
            if (bit_q == 5'd23) word_d[23:16] = byte_now;
            if (bit_q == 5'd31) begin
              mem_we = 1'b1;
              if (word_cnt_q == WORD_LAST) last_d = 1'b1;
              else word_cnt_d = word_cnt_q + 9'd1;
            end
          end
        end else begin
          if (state_q == ST_CMD || state_q == ST_ADDR) begin
            tx_sr_d = {tx_sr_q[30:0], 1'b0};
            bit_d   = bit_q + 5'd1;
            if (state_q == ST_CMD && bit_q == 5'd7) state_d = ST_ADDR;
            if (state_q == ST_ADDR && bit_q == 5'd31) begin
              state_d = ST_READ;
              bit_d   = '0;
            end
          end else if (last_q) begin
            state_d = ST_UART;
          end
        end
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end

    if (state_q == ST_UART) begin
      if (!uart_sent_q) begin
        uart_start  = 1'b1;
        uart_sent_d = 1'b1;
      end else if (!uart_busy) begin
        state_d = ST_DONE;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_CMD;
      run_q       <= 1'b0;
      sclk_q      <= 1'b0;
      div_q       <= '0;
      bit_q       <= '0;
      tx_sr_q     <= {SPI_READ_OP, SPI_BOOT_ADDR};
      rx_byte_q   <= '0;
      word_q      <= '0;
      word_cnt_q  <= '0;
      last_q      <= 1'b0;
      uart_sent_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      sclk_q      <= sclk_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      tx_sr_q     <= tx_sr_d;
      rx_byte_q   <= rx_byte_d;
      word_q      <= word_d;
      word_cnt_q  <= word_cnt_d;
      last_q      <= last_d;
      uart_sent_q <= uart_sent_d;
    end
  end

  // Boot image survives reset; only a fresh boot overwrites it.
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign dbg_data = mem_q[dbg_addr];

  uart_tx #(
    .UART_DIV(UART_DIV)
  ) u_uart_tx (
    .clock(clock),
    .reset(reset),
    .start(uart_start),
    .data (mem_q[0][7:0]),
    .tx   (uart_txd),
    .busy (uart_busy)
  );

  assign flash_csb = ~spi_active;
  assign flash_clk = sclk_q;
  assign flash_io0 = (spi_active && (state_q == ST_CMD || state_q == ST_ADDR)) ? tx_sr_q[31] : 1'b0;
  assign gpio      = (state_q == ST_DONE);
  assign mprj_oeb  = MPRJ_OEB;
  assign mprj_out  = {6'b0, checkbits_for(state_q, run_q), 9'b0, uart_txd, 6'b0};

endmodule

// File: tb/tb_caravel_mini.sv
// Randomised boot-image bench for caravel_mini with a behavioural SPI flash model.
module tb_caravel_mini;

  localparam int BW = 4;
  localparam int SD = 2;
  localparam int UD = 16;
  localparam int NBYTES = BW * 4;
  localparam int HDR_BITS = 32;
  localparam int DATA_BITS = NBYTES * 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flash_csb, flash_clk, flash_io0;
  logic        flash_io1 = 1'b0;
  logic [37:0] mprj_in = '0;
  logic [37:0] mprj_out, mprj_oeb;
  logic        gpio;
  logic [8:0]  dbg_addr = '0;
  logic [31:0] dbg_data;

  logic [7:0]  flash_bytes [NBYTES];
  int          rises = 0;
  int          idx;
  logic [31:0] mosi_cap = '0;

  int vectors = 0;
  int miscompares = 0;

  caravel_mini #(.BOOT_WORDS(BW), .SPI_DIV(SD), .UART_DIV(UD)) dut (
    .clock(clock), .reset(reset),
    .flash_csb(flash_csb), .flash_clk(flash_clk), .flash_io0(flash_io0), .flash_io1(flash_io1),
    .mprj_in(mprj_in), .mprj_out(mprj_out), .mprj_oeb(mprj_oeb), .gpio(gpio),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clock = ~clock;

  // Flash: capture command/address, then serve bytes MSB first, changing data on falling SCK.
  always @(negedge flash_csb) begin
    rises = 0;
    mosi_cap = '0;
  end

  always @(posedge flash_clk) begin
    if (flash_csb === 1'b0) begin
      if (rises < HDR_BITS) mosi_cap = {mosi_cap[30:0], flash_io0};
      rises++;
    end
  end

  always @(negedge flash_clk) begin
    if (flash_csb === 1'b0 && rises >= HDR_BITS && rises < HDR_BITS + DATA_BITS) begin
      idx = rises - HDR_BITS;
      flash_io1 = flash_bytes[idx / 8][7 - (idx % 8)];
    end
  end

  function automatic logic [37:0] exp_oeb();
    logic [37:0] r;
    for (int i = 0; i < 38; i++) r[i] = !(i == 6 || (i >= 16 && i <= 31));
    return r;
  endfunction

  task automatic load_fixed();
    for (int i = 0; i < NBYTES; i++) flash_bytes[i] = (i % 4 == 0) ? 8'(i / 4 + 1) : 8'h00;
  endtask

  task automatic load_random(input logic [7:0] first);
    for (int i = 0; i < NBYTES; i++) flash_bytes[i] = 8'($urandom);
    flash_bytes[0] = first;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    vectors++;
    if ({flash_csb, flash_clk, flash_io0, mprj_out[6], mprj_out[31:16], gpio} !== {1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got csb=%b clk=%b io0=%b tx=%b chk=%h gpio=%b, want 1 0 0 1 0000 0",
               flash_csb, flash_clk, flash_io0, mprj_out[6], mprj_out[31:16], gpio);
    end
    vectors++;
    if (mprj_oeb !== exp_oeb()) begin
      miscompares++;
      $display("[TB] FAIL reset_oeb: got %h want %h", mprj_oeb, exp_oeb());
    end
  endtask

  task automatic test_spi_header();
    int budget;
    int run;
    int changes;
    logic prev;
    budget = 0;
    while (flash_csb !== 1'b0 && budget < 100) begin
      @(negedge clock);
      budget++;
    end
    vectors++;
    if (flash_csb !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL csb_assert: csb=%b after %0d cycles, want 0", flash_csb, budget);
      return;
    end
    prev = flash_clk;
    run = 1;
    changes = 0;
    for (int cyc = 0; cyc < 2000 && changes < 2 * HDR_BITS; cyc++) begin
      @(negedge clock);
      if (flash_clk === prev) run++;
      else begin
        vectors++;
        if (run != SD) begin
          miscompares++;
          $display("[TB] FAIL sck_level: level %b lasted %0d clocks, want %0d", prev, run, SD);
        end
        changes++;
        prev = flash_clk;
        run = 1;
      end
    end
    vectors++;
    if (changes != 2 * HDR_BITS) begin
      miscompares++;
      $display("[TB] FAIL sck_edges: saw %0d edges, want %0d", changes, 2 * HDR_BITS);
    end
    vectors++;
    if (mosi_cap !== {8'h03, 24'h000000} || rises != HDR_BITS) begin
      miscompares++;
      $display("[TB] FAIL mosi_header: got %h after %0d bits, want 03000000 after %0d", mosi_cap, rises, HDR_BITS);
    end
  endtask

  task automatic test_status_during_boot();
    int budget;
    budget = 0;
    while (flash_csb !== 1'b0 && budget < 100) begin
      @(negedge clock);
      budget++;
    end
    budget = 0;
    while (flash_csb === 1'b0 && budget < 5000) begin
      vectors++;
      if ({mprj_out[31:16], gpio, mprj_oeb, mprj_out & exp_oeb()} !== {16'h0001, 1'b0, exp_oeb(), 38'b0}) begin
        miscompares++;
        $display("[TB] FAIL boot_status: chk=%h gpio=%b oeb=%h out=%h, want chk=0001 gpio=0 oeb=%h",
                 mprj_out[31:16], gpio, mprj_oeb, mprj_out, exp_oeb());
      end
      @(negedge clock);
      budget++;
    end
    vectors++;
    if (flash_csb !== 1'b1 || flash_clk !== 1'b0 || rises != HDR_BITS + DATA_BITS) begin
      miscompares++;
      $display("[TB] FAIL boot_end: csb=%b clk=%b sck_rises=%0d, want 1 0 %0d", flash_csb, flash_clk, rises, HDR_BITS + DATA_BITS);
    end
  endtask

  task automatic test_uart_frame(input logic [7:0] b);
    logic [9:0] frame;
    logic bit_bad;
    int budget;
    frame = {1'b1, b, 1'b0};
    budget = 0;
    while (mprj_out[6] !== 1'b0 && budget < 20 * UD) begin
      @(negedge clock);
      budget++;
    end
    vectors++;
    if (mprj_out[6] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL uart_start: no start bit within %0d clocks", budget);
      return;
    end
    for (int k = 0; k < 10; k++) begin
      bit_bad = 1'b0;
      for (int j = 0; j < UD; j++) begin
        if (k != 0 || j != 0) @(negedge clock);
        if (mprj_out[6] !== frame[k]) bit_bad = 1'b1;
      end
      vectors++;
      if (bit_bad) begin
        miscompares++;
        $display("[TB] FAIL uart_bit%0d: line not held at %b for %0d clocks (byte %h)", k, frame[k], UD, b);
      end
    end
    budget = 0;
    while (gpio !== 1'b1 && budget < 10) begin
      @(negedge clock);
      budget++;
    end
    vectors++;
    if ({gpio, mprj_out[31:16], mprj_out[6], flash_csb, flash_clk} !== {1'b1, 16'h0002, 1'b1, 1'b1, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL done_state: gpio=%b chk=%h tx=%b csb=%b clk=%b, want 1 0002 1 1 0",
               gpio, mprj_out[31:16], mprj_out[6], flash_csb, flash_clk);
    end
    repeat (40) @(negedge clock);
    vectors++;
    if ({gpio, mprj_out[31:16], mprj_out[6], flash_csb} !== {1'b1, 16'h0002, 1'b1, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL done_terminal: gpio=%b chk=%h tx=%b csb=%b, want 1 0002 1 1",
               gpio, mprj_out[31:16], mprj_out[6], flash_csb);
    end
  endtask

  task automatic test_sram_contents();
    logic [31:0] expw;
    for (int i = 0; i < BW; i++) begin
      dbg_addr = 9'(i);
      #1;
      expw = {flash_bytes[4*i+3], flash_bytes[4*i+2], flash_bytes[4*i+1], flash_bytes[4*i]};
      vectors++;
      if (dbg_data !== expw) begin
        miscompares++;
        $display("[TB] FAIL sram_word%0d: got %h want %h", i, dbg_data, expw);
      end
    end
    @(negedge clock);
  endtask

  task automatic start_boot(input logic [7:0] first);
    @(negedge clock);
    reset = 1'b1;
    load_random(first);
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    int budget;
    start_boot(8'($urandom));
    budget = 0;
    while (rises < HDR_BITS + DATA_BITS / 2 && budget < 4000) begin
      @(negedge clock);
      budget++;
    end
    vectors++;
    if (rises < HDR_BITS + DATA_BITS / 2) begin
      miscompares++;
      $display("[TB] FAIL midread_reach: only %0d SCK rises, want %0d", rises, HDR_BITS + DATA_BITS / 2);
    end
    #3;
    reset = 1'b1;
    #1;
    vectors++;
    if ({flash_csb, flash_clk, flash_io0, mprj_out[6], mprj_out[31:16], gpio} !== {1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL midread_reset: got csb=%b clk=%b io0=%b tx=%b chk=%h gpio=%b, want 1 0 0 1 0000 0",
               flash_csb, flash_clk, flash_io0, mprj_out[6], mprj_out[31:16], gpio);
    end
    @(negedge clock);
    load_random(8'hA5);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    test_status_during_boot();
    test_uart_frame(8'hA5);
    test_sram_contents();
  endtask

  task automatic test_back_to_back();
    logic [7:0] first;
    for (int n = 0; n < 2; n++) begin
      first = 8'($urandom);
      start_boot(first);
      test_spi_header();
      test_status_during_boot();
      test_uart_frame(first);
      test_sram_contents();
    end
  endtask

  initial begin
    test_reset();
    load_fixed();
    @(negedge clock);
    reset = 1'b0;
    test_spi_header();
    test_status_during_boot();
    test_uart_frame(8'h01);
    test_sram_contents();
    test_reset_mid_read();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete, %0d vectors so far", vectors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
